// File: rtl/console_pkg.sv
`default_nettype none
// ============================================================================
// Module   : console_pkg
// Purpose  : Shared command encodings, status bit map and FSM states.
// Revision : 1.0
// ============================================================================
package console_pkg;

   localparam logic [1:0] CMD_NOP    = 2'b00;
   localparam logic [1:0] CMD_PUTC   = 2'b01;
   localparam logic [1:0] CMD_FINISH = 2'b10;
   localparam logic [1:0] CMD_RSVD   = 2'b11;

   // Command field sits at wdata[17:16]
   localparam int CMD_LSB = 16;

   localparam int STAT_BUSY_BIT = 8;
   localparam int STAT_OVF_BIT  = 9;
   localparam int STAT_FINI_BIT = 10;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : 8N1 serializer; accepts a new byte during the last stop cycle.
// Revision : 1.0
// ============================================================================
module uart_tx #(
   parameter int BAUD_DIV = 868
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] i_data,
   input  logic       i_valid,
   output logic       o_ready,
   output logic       o_busy,
   output logic       o_txd
);

   localparam logic [15:0] c_baud_last = 16'(BAUD_DIV - 1);

   logic       r_active;
   logic       r_txd;
   logic [8:0] r_shift;
   logic [3:0] r_bit;
   logic [15:0] r_baud;
   logic       w_last;
   logic       w_load;

   // Ready in the final stop-bit cycle so back-to-back frames have no gap
   assign w_last  = r_active && (r_bit == 4'd9) && (r_baud == c_baud_last);
   assign o_ready = !r_active || w_last;
   assign w_load  = i_valid && o_ready;
   assign o_busy  = r_active;
   assign o_txd   = r_txd;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_active <= 1'b0;
         r_txd    <= 1'b1;
         r_shift  <= '0;
         r_bit    <= '0;
         r_baud   <= '0;
      end else if (w_load) begin
         r_active <= 1'b1;
         r_txd    <= 1'b0;
         r_shift  <= {1'b1, i_data};
         r_bit    <= '0;
         r_baud   <= '0;
      end else if (r_active) begin
         if (r_baud == c_baud_last) begin
            r_baud <= '0;
            if (r_bit == 4'd9) begin
               r_active <= 1'b0;
               r_txd    <= 1'b1;
            end else begin
               r_txd   <= r_shift[0];
               r_shift <= {1'b1, r_shift[8:1]};
               r_bit   <= r_bit + 4'd1;
            end
         end else begin
            r_baud <= r_baud + 16'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/console_mmio.sv
`default_nettype none
// ============================================================================
// Module   : console_mmio
// Purpose  : MMIO console/finish responder: PUTC FIFO into UART, drained finish.
// Revision : 1.0
// ============================================================================
module console_mmio
   import console_pkg::*;
#(
   parameter logic [31:0] ADDR       = 32'h40008000,
   parameter int          BAUD_DIV   = 868,
   parameter int          FIFO_DEPTH = 16
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [31:0] dbus_addr_i,
   input  logic        dbus_we_i,
   input  logic [31:0] dbus_wdata_i,
   input  logic        dbus_re_i,
   output logic [31:0] dbus_rdata_o,
   output logic        txd_o,
   output logic        fini_o,
   output logic [7:0]  exit_code_o
);

   localparam int c_ptr_w = $clog2(FIFO_DEPTH);
   localparam int c_cnt_w = c_ptr_w + 1;
   localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(FIFO_DEPTH);

   logic [7:0]         r_mem [FIFO_DEPTH];
   logic [c_ptr_w-1:0] r_wptr;
   logic [c_ptr_w-1:0] r_rptr;
   logic [c_cnt_w-1:0] r_count;
   logic               r_ovf;
   state_t             r_state;
   logic               r_fini;
   logic [7:0]         r_exit;
   logic [31:0]        r_rdata;

   logic        w_match;
   logic        w_store;
   logic [1:0]  w_cmd;
   logic        w_putc;
   logic        w_push;
   logic        w_pop;
   logic        w_nonempty;
   logic        w_tx_ready;
   logic        w_tx_busy;
   logic [31:0] w_status;
   logic        w_unused_bits;

   assign w_match    = (dbus_addr_i[31:2] == ADDR[31:2]);
   assign w_store    = dbus_we_i && w_match;
   assign w_cmd      = dbus_wdata_i[CMD_LSB+1:CMD_LSB];
   assign w_putc     = w_store && (w_cmd == CMD_PUTC) && (r_state == ST_RUN);
   // Acceptance looks only at the registered count, never at a same-cycle pop
   assign w_push     = w_putc && (r_count < c_depth);
   assign w_nonempty = (r_count != '0);
   assign w_pop      = w_nonempty && w_tx_ready;

   assign w_unused_bits = &{1'b0, dbus_addr_i[1:0], dbus_wdata_i[31:18], dbus_wdata_i[15:8]};

   always_comb begin
      w_status                = {24'h0, 8'(r_count)};
      w_status[STAT_BUSY_BIT] = w_tx_busy;
      w_status[STAT_OVF_BIT]  = r_ovf;
      w_status[STAT_FINI_BIT] = r_fini;
   end

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wptr] <= dbus_wdata_i[7:0];
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
         r_state <= ST_RUN;
         r_fini  <= 1'b0;
         r_exit  <= 8'h00;
         r_rdata <= 32'h0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_putc && !w_push) begin
            r_ovf <= 1'b1;
         end
         r_rdata <= (dbus_re_i && w_match) ? w_status : 32'h0;

         case (r_state)
            ST_RUN: begin
               if (w_store && (w_cmd == CMD_FINISH)) begin
                  r_exit  <= dbus_wdata_i[7:0];
                  r_state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               // Idle transmitter means the last stop bit has fully left the wire
               if (!w_nonempty && !w_tx_busy) begin
                  r_state <= ST_DONE;
                  r_fini  <= 1'b1;
               end
            end
            default: begin
               r_state <= r_state;
            end
         endcase
      end
   end

   uart_tx #(
      .BAUD_DIV (BAUD_DIV)
   ) u_uart_tx (
      .clk     (clk_i),
      .rst_n   (rst_ni),
      .i_data  (r_mem[r_rptr]),
      .i_valid (w_nonempty),
      .o_ready (w_tx_ready),
      .o_busy  (w_tx_busy),
      .o_txd   (txd_o)
   );

   assign dbus_rdata_o = r_rdata;
   assign fini_o       = r_fini;
   assign exit_code_o  = r_exit;

endmodule
`default_nettype wire
